// File: rtl/seg_pkg.sv
// Shared types and sizes for the seven-segment BCD feeder.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        WRITE = 2'd2
    } seg_state_t;

    localparam int          BCD_DIGITS = 5;
    localparam int          BIN_W      = 16;
    localparam int          SHIFT_W    = 36;
    localparam logic [15:0] DISP_MAX   = 16'd9999;

endpackage

// File: rtl/seg_bcd_feeder_bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added before the shift.
module bcd_add3 (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    // Inputs never exceed 9 here, so the 4-bit sum cannot carry out.
    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/seg_bcd_feeder.sv
// Converts a 16-bit binary value to packed BCD and writes it to the display slave
// with a single-beat STB/ACK transfer; values of 10000 or more become OVF_PATTERN.
module seg_bcd_feeder
    import seg_pkg::*;
#(
    parameter logic [15:0] OVF_PATTERN = 16'hEEEE,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             bin_valid,
    output logic             bin_ready,
    output logic             STB,
    output logic [15:0]      DAT_O,
    input  logic             ACK,
    output logic             ovf,
    output logic             err
);

    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

    seg_state_t         state_q, state_d;
    logic [SHIFT_W-1:0] sh_q, sh_d;
    logic [3:0]         step_q, step_d;
    logic [15:0]        tmo_q, tmo_d;
    logic               stb_q, stb_d;
    logic [15:0]        dat_q, dat_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    logic [SHIFT_W-1:0] adj;
    logic [SHIFT_W-1:0] shifted;

    assign adj[BIN_W-1:0] = sh_q[BIN_W-1:0];

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .d_i (sh_q[BIN_W + 4*g +: 4]),
            .d_o (adj[BIN_W + 4*g +: 4])
        );
    end

    assign shifted = {adj[SHIFT_W-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        step_d  = step_q;
        tmo_d   = tmo_q;
        dat_d   = dat_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bin_valid) begin
                    sh_d    = {20'b0, bin_in};
                    step_d  = 4'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                sh_d   = shifted;
                step_d = step_q + 4'd1;
                if (step_q == 4'd15) begin
                    state_d = WRITE;
                    tmo_d   = 16'd0;
                    // A non-zero ten-thousands digit cannot be shown on four digits.
                    if (shifted[35:32] != 4'd0) begin
                        dat_d = OVF_PATTERN;
                        ovf_d = 1'b1;
                    end else begin
                        dat_d = shifted[31:16];
                        ovf_d = 1'b0;
                    end
                end
            end
            WRITE: begin
                if (ACK) begin
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // STB is registered from the next state so it is high exactly while in WRITE.
    assign stb_d = (state_d == WRITE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            step_q  <= 4'd0;
            tmo_q   <= 16'd0;
            stb_q   <= 1'b0;
            dat_q   <= 16'h0000;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            step_q  <= step_d;
            tmo_q   <= tmo_d;
            stb_q   <= stb_d;
            dat_q   <= dat_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign bin_ready = (state_q == IDLE);
    assign STB       = stb_q;
    assign DAT_O     = dat_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule
